id_hazard_scoreboard: RTL

//  Parametrised ID-stage hazard/forwarding unit. Generates per-source forward selects (EX/MEM, MEM/WB, regfile).

---
 rtl/id_hazard_scoreboard_if.sv | 58 +++++
 rtl/id_hazard_scoreboard.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/id_hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_hazard_scoreboard_if
//  Description : Bundle of ID-stage hazard signals shared between the
//                pipeline (master) and the hazard/forwarding unit (slave).
//                master drives the ID/EX/MEM/WB pipeline state and the
//                long-latency issue request, and receives the forward
//                selects, stall, scoreboard occupancy and stall counter.
//  Revision    : 1.0  initial release
// ============================================================================
interface id_hazard_scoreboard_if #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int SB_DEPTH = 4,
    parameter int LAT_W    = 3
);
    localparam int c_cnt_w = $clog2(SB_DEPTH + 1);

    // pipeline -> hazard unit
    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_src_addr;
    logic [NUM_SRC-1:0]        id_src_used;
    logic                      id_ex_regwrite;
    logic [REG_AW-1:0]         id_ex_rd;
    logic                      ex_mem_regwrite;
    logic                      ex_mem_is_load;
    logic [REG_AW-1:0]         ex_mem_rd;
    logic                      mem_wb_regwrite;
    logic [REG_AW-1:0]         mem_wb_rd;
    logic                      lo_issue;
    logic [REG_AW-1:0]         lo_rd;
    logic [LAT_W-1:0]          lo_lat;

    // hazard unit -> pipeline
    logic [NUM_SRC*2-1:0]      id_fwd_sel;
    logic                      stall;
    logic [c_cnt_w-1:0]        sb_count;
    logic [31:0]               stall_cnt;

    modport master (
        output id_valid, id_src_addr, id_src_used,
        output id_ex_regwrite, id_ex_rd,
        output ex_mem_regwrite, ex_mem_is_load, ex_mem_rd,
        output mem_wb_regwrite, mem_wb_rd,
        output lo_issue, lo_rd, lo_lat,
        input  id_fwd_sel, stall, sb_count, stall_cnt
    );

    modport slave (
        input  id_valid, id_src_addr, id_src_used,
        input  id_ex_regwrite, id_ex_rd,
        input  ex_mem_regwrite, ex_mem_is_load, ex_mem_rd,
        input  mem_wb_regwrite, mem_wb_rd,
        input  lo_issue, lo_rd, lo_lat,
        output id_fwd_sel, stall, sb_count, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/id_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : id_hazard_scoreboard
//  Description : ID-stage hazard and forwarding unit. Produces per-source
//                forward selects (00 regfile, 01 EX/MEM, 10 MEM/WB) and a
//                stall for hazards forwarding cannot cover: ID/EX producer,
//                load in EX/MEM, or a pending long-latency write tracked in
//                a small scoreboard of countdown timers.
//  Ports       : clk      - clock, rising edge
//                rst_n    - synchronous reset, active low
//                bus      - id_hazard_scoreboard_if.slave (pipeline state in,
//                           id_fwd_sel / stall / sb_count / stall_cnt out)
//  Options     : ID_HAZARD_PERF_EN - when defined, stall_cnt is a saturating
//                count of cycles with stall & id_valid; otherwise tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module id_hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int SB_DEPTH = 4,
    parameter int LAT_W    = 3
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    id_hazard_scoreboard_if.slave   bus
);
    localparam int                 c_cnt_w   = $clog2(SB_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(SB_DEPTH);
    localparam logic [LAT_W-1:0]   c_lat_one = LAT_W'(1);

    // Scoreboard state
    logic [SB_DEPTH-1:0] r_sb_valid;
    logic [REG_AW-1:0]   r_sb_rd  [SB_DEPTH];
    logic [LAT_W-1:0]    r_sb_cnt [SB_DEPTH];
    logic [c_cnt_w-1:0]  r_sb_count;

    // Hazard / forwarding decode
    logic [NUM_SRC*2-1:0] w_fwd_sel;
    logic [REG_AW-1:0]    w_addr;
    logic                 w_live;
    logic                 w_src_stall;
    logic                 w_lo_req;
    logic                 w_lo_waw;
    logic                 w_lo_stall;
    logic                 w_stall;

    always_comb begin
        w_fwd_sel   = '0;
        w_addr      = '0;
        w_live      = 1'b0;
        w_src_stall = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            w_addr = bus.id_src_addr[s*REG_AW +: REG_AW];
            w_live = bus.id_valid & bus.id_src_used[s] & (w_addr != '0);
            if (w_live) begin
                // A load in EX/MEM has no data yet, so it never forwards.
                if (bus.ex_mem_regwrite && !bus.ex_mem_is_load && (bus.ex_mem_rd == w_addr))
                    w_fwd_sel[s*2 +: 2] = 2'b01;
                else if (bus.mem_wb_regwrite && (bus.mem_wb_rd == w_addr))
                    w_fwd_sel[s*2 +: 2] = 2'b10;

                if (bus.id_ex_regwrite && (bus.id_ex_rd == w_addr))
                    w_src_stall = 1'b1;
                if (bus.ex_mem_regwrite && bus.ex_mem_is_load && (bus.ex_mem_rd == w_addr))
                    w_src_stall = 1'b1;
                for (int e = 0; e < SB_DEPTH; e++) begin
                    if (r_sb_valid[e] && (r_sb_rd[e] == w_addr))
                        w_src_stall = 1'b1;
                end
            end
        end
    end

    // Long-latency issue: blocked when the scoreboard is full (registered
    // count, so a same-cycle retire does not free a slot) or on WAW.
    always_comb begin
        w_lo_req = bus.id_valid & bus.lo_issue & (bus.lo_rd != '0);
        w_lo_waw = 1'b0;
        for (int e = 0; e < SB_DEPTH; e++) begin
            if (r_sb_valid[e] && (r_sb_rd[e] == bus.lo_rd))
                w_lo_waw = 1'b1;
        end
        w_lo_stall = w_lo_req & ((r_sb_count == c_full) | w_lo_waw);
    end

    assign w_stall        = rst_n & (w_src_stall | w_lo_stall);
    assign bus.stall      = w_stall;
    assign bus.id_fwd_sel = rst_n ? w_fwd_sel : '0;
    assign bus.sb_count   = r_sb_count;

    // Allocation into the lowest free entry
    logic                w_alloc_en;
    logic                w_found;
    logic [SB_DEPTH-1:0] w_alloc_vec;
    logic [LAT_W-1:0]    w_lat_eff;
    logic [SB_DEPTH-1:0] w_valid_nxt;
    logic [c_cnt_w-1:0]  w_count_nxt;

    // A zero latency still needs one cycle of protection.
    assign w_lat_eff  = (bus.lo_lat == '0) ? c_lat_one : bus.lo_lat;
    assign w_alloc_en = w_lo_req & ~w_stall;

    always_comb begin
        w_alloc_vec = '0;
        w_found     = 1'b0;
        for (int e = 0; e < SB_DEPTH; e++) begin
            if (!w_found && !r_sb_valid[e]) begin
                w_alloc_vec[e] = w_alloc_en;
                w_found        = 1'b1;
            end
        end
    end

    // An entry with count 1 retires at this edge; sb_count is the
    // population of the resulting valid vector.
    always_comb begin
        w_valid_nxt = '0;
        w_count_nxt = '0;
        for (int e = 0; e < SB_DEPTH; e++) begin
            w_valid_nxt[e] = w_alloc_vec[e] | (r_sb_valid[e] & (r_sb_cnt[e] != c_lat_one));
            w_count_nxt    = w_count_nxt + c_cnt_w'(w_valid_nxt[e]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sb_valid <= '0;
            r_sb_count <= '0;
            for (int e = 0; e < SB_DEPTH; e++) begin
                r_sb_rd[e]  <= '0;
                r_sb_cnt[e] <= '0;
            end
        end else begin
            r_sb_valid <= w_valid_nxt;
            r_sb_count <= w_count_nxt;
            for (int e = 0; e < SB_DEPTH; e++) begin
                if (w_alloc_vec[e]) begin
                    r_sb_rd[e]  <= bus.lo_rd;
                    r_sb_cnt[e] <= w_lat_eff;
                end else if (r_sb_valid[e]) begin
                    r_sb_cnt[e] <= r_sb_cnt[e] - c_lat_one;
                end
            end
        end
    end

`ifdef ID_HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_stall_cnt <= 32'h0;
        else if (w_stall && bus.id_valid && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.stall_cnt = 32'h0;
`endif

endmodule
`default_nettype wire
